tm1638_frame_tx: RTL and testbench

- Downstream display stage for the BCD time-of-day counter.
- Latches eight 4-bit hex digits and eight LED bits, converts each digit to a 7-segment pattern, and serialises a full refresh frame to a TM1638 board controller over STB/CLK/DIO.
- One frame is three STB-framed transactions: data command, address plus 16 display bytes, and display control.

---
 rtl/tm1638_frame_tx.sv | 188 ++++++++++++++++++
 tb/tb_tm1638_frame_tx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_frame_tx.sv
// TM1638 refresh-frame transmitter: latches eight hex digits, LEDs and brightness,
// then sends data command, 16 display bytes and display control over STB/CLK/DIO.
module tm1638_frame_tx #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   input  logic [3:0] seg0,
   input  logic [3:0] seg1,
   input  logic [3:0] seg2,
   input  logic [3:0] seg3,
   input  logic [3:0] seg4,
   input  logic [3:0] seg5,
   input  logic [3:0] seg6,
   input  logic [3:0] seg7,
   input  logic [7:0] led,
   input  logic [2:0] bright,
   input  logic       disp_on,
   output logic       busy,
   output logic       done,
   output logic       tm_stb,
   output logic       tm_clk,
   output logic       tm_dio
);

   typedef enum logic [2:0] {IDLE, SETUP, BIT_LO, BIT_HI, HOLD, GAP, DONE} state_t;

   localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

   state_t     state;
   logic [7:0] div_cnt;
   logic [1:0] txn;
   logic [4:0] byte_idx;
   logic [2:0] bit_idx;

   logic [3:0] dig_q [8];
   logic [7:0] led_q;
   logic [2:0] bright_q;
   logic       disp_on_q;

   logic       tick;
   logic       last_bit;
   logic       last_byte;
   logic [4:0] nxt_idx;
   logic [2:0] nxt_bit;
   logic [4:0] sel_idx;
   logic [2:0] sel_bit;
   logic [7:0] sel_byte;

   function automatic logic [7:0] seg7_of(input logic [3:0] d);
      case (d)
         4'h0: seg7_of = 8'h3F;  4'h1: seg7_of = 8'h06;
         4'h2: seg7_of = 8'h5B;  4'h3: seg7_of = 8'h4F;
         4'h4: seg7_of = 8'h66;  4'h5: seg7_of = 8'h6D;
         4'h6: seg7_of = 8'h7D;  4'h7: seg7_of = 8'h07;
         4'h8: seg7_of = 8'h7F;  4'h9: seg7_of = 8'h6F;
         4'hA: seg7_of = 8'h77;  4'hB: seg7_of = 8'h7C;
         4'hC: seg7_of = 8'h39;  4'hD: seg7_of = 8'h5E;
         4'hE: seg7_of = 8'h79;  default: seg7_of = 8'h71;
      endcase
   endfunction

   // Byte i of transaction t; in T2, odd positions carry digits and even ones LEDs.
   function automatic logic [7:0] byte_at(input logic [1:0] t, input logic [4:0] i);
      logic [2:0] k;
      k = 3'((i - 5'd1) >> 1);
      if (t == 2'd0)
         byte_at = 8'h40;
      else if (t == 2'd2)
         byte_at = disp_on_q ? (8'h88 | {5'b0, bright_q}) : 8'h80;
      else if (i == 5'd0)
         byte_at = 8'hC0;
      else if (i[0])
         byte_at = seg7_of(dig_q[k]);
      else
         byte_at = {7'b0, led_q[k]};
   endfunction

   // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      tick      = (div_cnt == DIV_MAX);
      last_bit  = (bit_idx == 3'd7);
      last_byte = (txn == 2'd1) ? (byte_idx == 5'd16) : (byte_idx == 5'd0);
      nxt_idx   = last_bit ? byte_idx + 5'd1 : byte_idx;
      nxt_bit   = bit_idx + 3'd1;
      sel_idx   = (state == SETUP) ? 5'd0 : nxt_idx;
      sel_bit   = (state == SETUP) ? 3'd0 : nxt_bit;
      sel_byte  = byte_at(txn, sel_idx);
   end

   // NOTE: the payload registers carry no reset; they are always written before being used.
   always_ff @(posedge CLK) begin
      if (!RST && state == IDLE && start) begin
         dig_q     <= '{seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7};
         led_q     <= led;
         bright_q  <= bright;
         disp_on_q <= disp_on;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         div_cnt  <= '0;
         txn      <= '0;
         byte_idx <= '0;
         bit_idx  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tm_stb   <= 1'b1;
         tm_clk   <= 1'b1;
         tm_dio   <= 1'b1;
      end else begin
         if (state != IDLE && state != DONE)
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= SETUP;
                  busy     <= 1'b1;
                  tm_stb   <= 1'b0;
                  txn      <= 2'd0;
                  byte_idx <= 5'd0;
                  bit_idx  <= 3'd0;
                  div_cnt  <= 8'd0;
               end
            end
            SETUP: begin
               if (tick) begin
                  state  <= BIT_LO;
                  tm_clk <= 1'b0;
                  tm_dio <= sel_byte[sel_bit];
               end
            end
            BIT_LO: begin
               if (tick) begin
                  state  <= BIT_HI;
                  tm_clk <= 1'b1;
               end
            end
            BIT_HI: begin
               if (tick) begin
                  if (last_bit && last_byte) begin
                     state <= HOLD;
                  end else begin
                     state    <= BIT_LO;
                     tm_clk   <= 1'b0;
                     tm_dio   <= sel_byte[sel_bit];
                     bit_idx  <= nxt_bit;
                     byte_idx <= nxt_idx;
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  state  <= GAP;
                  tm_stb <= 1'b1;
                  tm_dio <= 1'b1;
               end
            end
            GAP: begin
               if (tick) begin
                  if (txn == 2'd2) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= SETUP;
                     txn      <= txn + 2'd1;
                     byte_idx <= 5'd0;
                     bit_idx  <= 3'd0;
                     tm_stb   <= 1'b0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tm1638_frame_tx.sv
// Bench for tm1638_frame_tx: a slave model decodes STB/CLK/DIO into bytes and
// compares each frame against a byte list built from the display inputs.
module tb_tm1638_frame_tx;

   localparam int CLK_DIV = 4;
   localparam int FRAME_LAT = 313 * CLK_DIV;
   localparam logic [7:0] SEG_TAB [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] seg [8];
   logic [7:0] led = '0;
   logic [2:0] bright = '0;
   logic       disp_on = 1'b0;
   logic       busy, done, tm_stb, tm_clk, tm_dio;

   int total = 0;
   int bad = 0;

   tm1638_frame_tx #(.CLK_DIV(CLK_DIV)) dut (
      .CLK(clk), .RST(rst), .start(start),
      .seg0(seg[0]), .seg1(seg[1]), .seg2(seg[2]), .seg3(seg[3]),
      .seg4(seg[4]), .seg5(seg[5]), .seg6(seg[6]), .seg7(seg[7]),
      .led(led), .bright(bright), .disp_on(disp_on),
      .busy(busy), .done(done), .tm_stb(tm_stb), .tm_clk(tm_clk), .tm_dio(tm_dio)
   );

   always #5 clk = ~clk;

   // Slave model: sampled on the falling system clock, well away from the active edge.
   logic [7:0] rx_q [$];
   int         len_q [$];
   logic [7:0] exp_q [$];
   int   cyc = 0, busy_cyc = 0, done_cnt = 0, done_lat = 0, clk_edges = 0;
   int   run = 0, nbits = 0, cur_len = 0;
   logic p_stb = 1'b1, p_clk = 1'b1, p_dio = 1'b1, p_busy = 1'b0;
   logic [7:0] sh = '0;

   always @(negedge clk) begin
      cyc++;
      if (!p_busy && busy === 1'b1) busy_cyc = cyc;
      if (done === 1'b1) begin
         done_cnt++;
         done_lat = cyc - busy_cyc;
      end
      if (tm_clk !== p_clk) clk_edges++;
      if (p_stb && !tm_stb) begin
         run = 1; nbits = 0; cur_len = 0;
      end else if (!p_stb && !tm_stb) begin
         if (tm_clk != p_clk) begin
            total++;
            if (run != CLK_DIV) begin
               bad++;
               $display("FAIL phase_len: got %0d cycles, required %0d (cycle %0d)", run, CLK_DIV, cyc);
            end
            run = 1;
         end else begin
            run++;
         end
         if (p_clk && tm_clk) begin
            total++;
            if (tm_dio !== p_dio) begin
               bad++;
               $display("FAIL dio_stable: dio moved %b->%b while clk high (cycle %0d)", p_dio, tm_dio, cyc);
            end
         end
         if (!p_clk && tm_clk) begin
            sh[nbits] = tm_dio;
            nbits++;
            if (nbits == 8) begin
               rx_q.push_back(sh);
               cur_len++;
               nbits = 0;
            end
         end
      end
      if (!p_stb && tm_stb) len_q.push_back(cur_len);
      p_stb = tm_stb; p_clk = tm_clk; p_dio = tm_dio; p_busy = busy;
   end

   // Expected frame built directly from the byte-list definition.
   task automatic build_expected();
      exp_q.delete();
      exp_q.push_back(8'h40);
      exp_q.push_back(8'hC0);
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(SEG_TAB[seg[k]]);
         exp_q.push_back({7'b0, led[k]});
      end
      exp_q.push_back(disp_on ? (8'h88 | {5'b0, bright}) : 8'h80);
   endtask

   task automatic start_frame();
      rx_q.delete();
      len_q.delete();
      done_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL %s_timeout: done not seen within %0d cycles", name, n);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if ({tm_stb, tm_clk, tm_dio, busy, done} !== 5'b11100) begin
            bad++;
            $display("FAIL reset_outputs: stb,clk,dio,busy,done=%b required 11100", {tm_stb, tm_clk, tm_dio, busy, done});
         end
         start = ~start;
      end
      rst = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || clk_edges != 0) begin
         bad++;
         $display("FAIL reset_quiet: busy=%b clk_edges=%0d required 0/0", busy, clk_edges);
      end
   endtask

   task automatic test_nominal();
      seg = '{4'h1, 4'h4, 4'hE, 4'h3, 4'h0, 4'hE, 4'h1, 4'h5};
      led = 8'hAA; bright = 3'd7; disp_on = 1'b1;
      build_expected();
      start_frame();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL nominal_busy: busy=%b required 1", busy);
      end
      wait_done("nominal");
      @(posedge clk); #1;
      total++;
      if (done_cnt != 1 || done_lat != FRAME_LAT || busy !== 1'b0) begin
         bad++;
         $display("FAIL nominal_done: count=%0d latency=%0d busy=%b required 1/%0d/0", done_cnt, done_lat, busy, FRAME_LAT);
      end
      total++;
      if (len_q.size() != 3 || len_q[0] != 1 || len_q[1] != 17 || len_q[2] != 1) begin
         bad++;
         $display("FAIL nominal_txns: %0d transactions, required 3 of 1/17/1 bytes", len_q.size());
      end
      total++;
      if (rx_q.size() != 19) begin
         bad++;
         $display("FAIL nominal_size: got %0d bytes required 19", rx_q.size());
      end
      for (int i = 0; i < rx_q.size() && i < 19; i++) begin
         total++;
         if (rx_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL nominal_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]);
         end
      end
      total++;
      if (rx_q.size() == 19 && (rx_q[1] !== 8'hC0 || rx_q[18] !== 8'h8F)) begin
         bad++;
         $display("FAIL nominal_cmds: addr=%h ctrl=%h required c0/8f", rx_q[1], rx_q[18]);
      end
   endtask

   task automatic test_busy_ignore();
      seg[0] = 4'h1;
      build_expected();
      start_frame();
      repeat (200) @(posedge clk);
      #1;
      start = 1'b1;
      seg[0] = 4'h9;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("busy_ignore");
      @(posedge clk); #1;
      total++;
      if (done_cnt != 1 || rx_q.size() != 19 || rx_q[2] !== 8'h06) begin
         bad++;
         $display("FAIL busy_ignore: done=%0d bytes=%0d D0=%h required 1/19/06", done_cnt, rx_q.size(), rx_q[2]);
      end
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || done_cnt != 1) begin
         bad++;
         $display("FAIL busy_restart: busy=%b done=%0d required 0/1", busy, done_cnt);
      end
      start_frame();
      wait_done("busy_next");
      @(posedge clk); #1;
      total++;
      if (rx_q.size() != 19 || rx_q[2] !== 8'h6F) begin
         bad++;
         $display("FAIL busy_next_d0: got %h required 6f", rx_q[2]);
      end
   endtask

   task automatic test_display_off();
      disp_on = 1'b0; bright = 3'd5;
      start_frame();
      wait_done("disp_off");
      @(posedge clk); #1;
      total++;
      if (rx_q.size() != 19 || rx_q[18] !== 8'h80) begin
         bad++;
         $display("FAIL disp_off_ctrl: got %h required 80", rx_q[18]);
      end
      disp_on = 1'b1; bright = 3'd0;
      start_frame();
      wait_done("disp_dim");
      @(posedge clk); #1;
      total++;
      if (rx_q.size() != 19 || rx_q[18] !== 8'h88) begin
         bad++;
         $display("FAIL disp_dim_ctrl: got %h required 88", rx_q[18]);
      end
   endtask

   task automatic test_done_cycle_start();
      start_frame();
      wait_done("done_start");
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || tm_stb !== 1'b1) begin
         bad++;
         $display("FAIL done_start: busy=%b stb=%b required 0/1", busy, tm_stb);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 8; k++) seg[k] = 4'($urandom_range(0, 15));
      led = 8'($urandom);
      build_expected();
      start_frame();
      repeat (99) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({tm_stb, tm_clk, tm_dio, busy, done} !== 5'b11100) begin
         bad++;
         $display("FAIL reset_mid: stb,clk,dio,busy,done=%b required 11100", {tm_stb, tm_clk, tm_dio, busy, done});
      end
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      total++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_quiet: done=%0d busy=%b required 0/0", done_cnt, busy);
      end
      start_frame();
      wait_done("reset_recover");
      @(posedge clk); #1;
      total++;
      if (rx_q.size() != 19 || done_cnt != 1) begin
         bad++;
         $display("FAIL reset_recover_size: bytes=%0d done=%0d required 19/1", rx_q.size(), done_cnt);
      end
      for (int i = 0; i < rx_q.size() && i < 19; i++) begin
         total++;
         if (rx_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL reset_recover_byte%0d: got %h required %h", i, rx_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < 8; k++) seg[k] = 4'($urandom_range(0, 15));
         led = 8'($urandom);
         bright = 3'($urandom_range(0, 7));
         disp_on = 1'($urandom_range(0, 1));
         build_expected();
         start_frame();
         wait_done("random");
         @(posedge clk); #1;
         total++;
         if (rx_q.size() != 19 || done_lat != FRAME_LAT) begin
            bad++;
            $display("FAIL random%0d_frame: bytes=%0d latency=%0d required 19/%0d", f, rx_q.size(), done_lat, FRAME_LAT);
         end
         for (int i = 0; i < rx_q.size() && i < 19; i++) begin
            total++;
            if (rx_q[i] !== exp_q[i]) begin
               bad++;
               $display("FAIL random%0d_byte%0d: got %h required %h", f, i, rx_q[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      seg = '{default: 4'h0};
      test_reset();
      test_nominal();
      test_busy_ignore();
      test_display_off();
      test_done_cycle_start();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
